// File: rtl/request_priority_encoder_pkg.sv
// Shared types and helpers for the latching, maskable request priority encoder.
package request_priority_encoder_pkg;

    typedef enum logic {
        REQ_IDLE  = 1'b0,
        REQ_GRANT = 1'b1
    } req_enc_state_t;

    localparam int REQ_COUNT_MAX = 32;

    // Lowest set bit of a request vector, -1 when empty; intended for sims and assertions.
    function automatic int lowest_index(input logic [REQ_COUNT_MAX-1:0] i_vec);
        int r_idx;
        r_idx = -1;
        for (int i = REQ_COUNT_MAX - 1; i >= 0; i--) begin
            if (i_vec[i]) r_idx = i;
        end
        return r_idx;
    endfunction

endpackage

// File: rtl/request_priority_encoder_if.sv
// Request/grant bundle between request sources, the encoder and its consumer.
interface request_priority_encoder_if #(
    parameter int REQ_COUNT = 8,
    parameter int IDX_W     = ($clog2(REQ_COUNT) == 0) ? 1 : $clog2(REQ_COUNT)
);
    logic [REQ_COUNT-1:0] req;
    logic [REQ_COUNT-1:0] mask;
    logic                 clear;
    logic                 ack;
    logic                 grant_valid;
    logic [IDX_W-1:0]     grant_idx;
    logic [REQ_COUNT-1:0] grant_onehot;
    logic [REQ_COUNT-1:0] pending;

    modport master (
        output req, mask, clear, ack,
        input  grant_valid, grant_idx, grant_onehot, pending
    );

    modport slave (
        input  req, mask, clear, ack,
        output grant_valid, grant_idx, grant_onehot, pending
    );
endinterface

// File: rtl/request_priority_encoder_priority_isolate.sv
// Combinational lowest-set-bit isolation: one-hot of the winner plus its binary index.
module request_priority_encoder_priority_isolate #(
    parameter int REQ_COUNT = 8,
    parameter int IDX_W     = ($clog2(REQ_COUNT) == 0) ? 1 : $clog2(REQ_COUNT)
) (
    input  logic [REQ_COUNT-1:0] i_vec,
    output logic [REQ_COUNT-1:0] o_onehot,
    output logic [IDX_W-1:0]     o_idx
);

    assign o_onehot = i_vec & (~i_vec + REQ_COUNT'(1));

    // Each index bit is the OR of the one-hot positions whose index has that bit set.
    always_comb begin
        o_idx = '0;
        for (int b = 0; b < IDX_W; b++) begin
            for (int i = 0; i < REQ_COUNT; i++) begin
                if (((i >> b) & 1) == 1) o_idx[b] = o_idx[b] | o_onehot[i];
            end
        end
    end

endmodule

// File: rtl/request_priority_encoder.sv
// Latching, maskable priority encoder; bit 0 highest priority, grant held until ack or clear.
// Optional REQ_ENC_EDGE_EN: pend only on rising edges of req instead of on level.
module request_priority_encoder
    import request_priority_encoder_pkg::*;
#(
    parameter  int REQ_COUNT = 8,
    localparam int IDX_W     = ($clog2(REQ_COUNT) == 0) ? 1 : $clog2(REQ_COUNT)
) (
    input  logic                          clk,
    input  logic                          nrst,
    request_priority_encoder_if.slave     bus
);

    req_enc_state_t       r_state, w_state_n;
    logic [REQ_COUNT-1:0] r_pending, w_pending_n;
    logic [REQ_COUNT-1:0] w_set, w_clr, w_eligible, w_arb_onehot;
    logic [IDX_W-1:0]     w_arb_idx;
    logic                 r_grant_valid, w_grant_valid_n;
    logic [IDX_W-1:0]     r_grant_idx, w_grant_idx_n;
    logic [REQ_COUNT-1:0] r_grant_onehot, w_grant_onehot_n;

`ifdef REQ_ENC_EDGE_EN
    logic [REQ_COUNT-1:0] r_req_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)          r_req_q <= '0;
        else if (bus.clear) r_req_q <= '0;
        else                r_req_q <= bus.req;
    end

    assign w_set = bus.req & ~r_req_q;
`else
    assign w_set = bus.req;
`endif

    // Set is OR-ed in after the ack clear so a simultaneous re-request survives.
    assign w_clr       = (bus.ack && r_grant_valid) ? r_grant_onehot : '0;
    assign w_pending_n = bus.clear ? '0 : ((r_pending & ~w_clr) | w_set);
    assign w_eligible  = r_pending & bus.mask;

    request_priority_encoder_priority_isolate #(
        .REQ_COUNT (REQ_COUNT),
        .IDX_W     (IDX_W)
    ) u_isolate (
        .i_vec    (w_eligible),
        .o_onehot (w_arb_onehot),
        .o_idx    (w_arb_idx)
    );

    // REQ_IDLE  | arbitrating over registered pending & mask
    // REQ_GRANT | grant presented and frozen until ack or clear
    always_comb begin
        w_state_n        = r_state;
        w_grant_valid_n  = r_grant_valid;
        w_grant_idx_n    = r_grant_idx;
        w_grant_onehot_n = r_grant_onehot;
        if (bus.clear) begin
            w_state_n        = REQ_IDLE;
            w_grant_valid_n  = 1'b0;
            w_grant_idx_n    = '0;
            w_grant_onehot_n = '0;
        end else begin
            case (r_state)
                REQ_IDLE: begin
                    if (|w_eligible) begin
                        w_state_n        = REQ_GRANT;
                        w_grant_valid_n  = 1'b1;
                        w_grant_idx_n    = w_arb_idx;
                        w_grant_onehot_n = w_arb_onehot;
                    end
                end
                REQ_GRANT: begin
                    if (bus.ack) begin
                        w_state_n        = REQ_IDLE;
                        w_grant_valid_n  = 1'b0;
                        w_grant_idx_n    = '0;
                        w_grant_onehot_n = '0;
                    end
                end
                default: begin
                    w_state_n        = REQ_IDLE;
                    w_grant_valid_n  = 1'b0;
                    w_grant_idx_n    = '0;
                    w_grant_onehot_n = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state        <= REQ_IDLE;
            r_pending      <= '0;
            r_grant_valid  <= 1'b0;
            r_grant_idx    <= '0;
            r_grant_onehot <= '0;
        end else begin
            r_state        <= w_state_n;
            r_pending      <= w_pending_n;
            r_grant_valid  <= w_grant_valid_n;
            r_grant_idx    <= w_grant_idx_n;
            r_grant_onehot <= w_grant_onehot_n;
        end
    end

    assign bus.grant_valid  = r_grant_valid;
    assign bus.grant_idx    = r_grant_idx;
    assign bus.grant_onehot = r_grant_onehot;
    assign bus.pending      = r_pending;

endmodule

// File: tb/tb_request_priority_encoder.sv
// Self-checking bench for request_priority_encoder: directed scenarios plus randomized traffic.
module tb_request_priority_encoder;
    localparam int N  = 8;
    localparam int IW = 3;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    // Reference state: pending set, previous req, granted source (-1 = none).
    logic [N-1:0] m_pend = '0;
    logic [N-1:0] m_reqq = '0;
    int           m_gidx = -1;

    request_priority_encoder_if #(.REQ_COUNT(N)) bus ();

    request_priority_encoder #(.REQ_COUNT(N)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Advance one clock; the model consumes the inputs present before the edge.
    task automatic step();
        logic [N-1:0] set_v, p_n, q_n;
        int           g_n;
        set_v = '0;
        if (!nrst || bus.clear) begin
            p_n = '0;
            q_n = '0;
            g_n = -1;
        end else begin
`ifdef REQ_ENC_EDGE_EN
            set_v = bus.req & ~m_reqq;
`else
            set_v = bus.req;
`endif
            p_n = m_pend;
            if (bus.ack && m_gidx >= 0) p_n[m_gidx] = 1'b0;
            p_n = p_n | set_v;
            q_n = bus.req;
            if (m_gidx < 0)   g_n = lowest(m_pend & bus.mask);
            else if (bus.ack) g_n = -1;
            else              g_n = m_gidx;
        end
        @(posedge clk);
        #1;
        m_pend = p_n;
        m_reqq = q_n;
        m_gidx = g_n;
    endtask

    task automatic test_reset();
        nrst      = 1'b0;
        bus.req   = 8'hFF;
        bus.mask  = 8'hFF;
        bus.clear = 1'b0;
        bus.ack   = 1'b0;
        #12;
        total++; if (bus.grant_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", bus.grant_valid); end
        total++; if (bus.grant_idx !== 3'd0) begin bad++; $display("FAIL rst_idx got=%0d want=0", bus.grant_idx); end
        total++; if (bus.grant_onehot !== 8'h00) begin bad++; $display("FAIL rst_onehot got=%h want=00", bus.grant_onehot); end
        total++; if (bus.pending !== 8'h00) begin bad++; $display("FAIL rst_pending got=%h want=00", bus.pending); end
        @(posedge clk);
        #1;
        m_pend = '0; m_reqq = '0; m_gidx = -1;
        nrst = 1'b1;
        step();
        total++; if (bus.pending !== 8'hFF) begin bad++; $display("FAIL rst_edge1_pending got=%h want=ff", bus.pending); end
        total++; if (bus.grant_valid !== 1'b0) begin bad++; $display("FAIL rst_edge1_valid got=%b want=0", bus.grant_valid); end
        bus.req = 8'h00;
        step();
        total++; if (bus.grant_valid !== 1'b1) begin bad++; $display("FAIL rst_edge2_valid got=%b want=1", bus.grant_valid); end
        total++; if (bus.grant_idx !== 3'd0) begin bad++; $display("FAIL rst_edge2_idx got=%0d want=0", bus.grant_idx); end
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        total++; if (bus.pending !== 8'h00 || bus.grant_valid !== 1'b0) begin bad++; $display("FAIL rst_flush got=%h/%b want=00/0", bus.pending, bus.grant_valid); end
    endtask

    task automatic test_priority();
        int          exp_idx [3] = '{2, 5, 7};
        logic [7:0]  exp_p   [3] = '{8'hA4, 8'hA0, 8'h80};
        int          cyc;
        bus.mask = 8'hFF;
        bus.req  = 8'hA4;
        step();
        bus.req  = 8'h00;
        total++; if (bus.pending !== 8'hA4) begin bad++; $display("FAIL prio_capture got=%h want=a4", bus.pending); end
        for (int k = 0; k < 3; k++) begin
            cyc = 0;
            while (!bus.grant_valid && cyc < 8) begin step(); cyc++; end
            total++; if (bus.grant_valid !== 1'b1) begin bad++; $display("FAIL prio_wait%0d got=%b want=1", k, bus.grant_valid); end
            total++; if (bus.grant_idx !== IW'(exp_idx[k])) begin bad++; $display("FAIL prio_idx%0d got=%0d want=%0d", k, bus.grant_idx, exp_idx[k]); end
            total++; if (bus.grant_onehot !== (8'h01 << exp_idx[k])) begin bad++; $display("FAIL prio_onehot%0d got=%h", k, bus.grant_onehot); end
            total++; if (bus.pending !== exp_p[k]) begin bad++; $display("FAIL prio_pending%0d got=%h want=%h", k, bus.pending, exp_p[k]); end
            bus.ack = 1'b1;
            step();
            bus.ack = 1'b0;
            total++; if (bus.grant_valid !== 1'b0) begin bad++; $display("FAIL prio_idle%0d got=%b want=0", k, bus.grant_valid); end
        end
        total++; if (bus.pending !== 8'h00) begin bad++; $display("FAIL prio_drained got=%h want=00", bus.pending); end
    endtask

    task automatic test_no_preempt();
        int cyc;
        bus.req = 8'h20;
        step();
        bus.req = 8'h00;
        cyc = 0;
        while (!bus.grant_valid && cyc < 8) begin step(); cyc++; end
        total++; if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 3'd5) begin bad++; $display("FAIL npre_first got=%b/%0d want=1/5", bus.grant_valid, bus.grant_idx); end
        bus.req = 8'h02;
        step();
        bus.req = 8'h00;
        step();
        step();
        total++; if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 3'd5) begin bad++; $display("FAIL npre_hold got=%b/%0d want=1/5", bus.grant_valid, bus.grant_idx); end
        total++; if (bus.pending !== 8'h22) begin bad++; $display("FAIL npre_pending got=%h want=22", bus.pending); end
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        total++; if (bus.grant_valid !== 1'b0 || bus.pending !== 8'h02) begin bad++; $display("FAIL npre_ack got=%b/%h want=0/02", bus.grant_valid, bus.pending); end
        step();
        total++; if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 3'd1) begin bad++; $display("FAIL npre_second got=%b/%0d want=1/1", bus.grant_valid, bus.grant_idx); end
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
    endtask

    task automatic test_mask();
        int cyc;
        bus.mask = 8'hFE;
        bus.req  = 8'h01;
        step();
        bus.req  = 8'h00;
        repeat (4) step();
        total++; if (bus.grant_valid !== 1'b0) begin bad++; $display("FAIL mask_blocked got=%b want=0", bus.grant_valid); end
        total++; if (bus.pending !== 8'h01) begin bad++; $display("FAIL mask_pending got=%h want=01", bus.pending); end
        bus.mask = 8'hFF;
        cyc = 0;
        while (!bus.grant_valid && cyc < 8) begin step(); cyc++; end
        total++; if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 3'd0) begin bad++; $display("FAIL mask_release got=%b/%0d want=1/0", bus.grant_valid, bus.grant_idx); end
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
    endtask

    task automatic test_clear();
        int cyc;
        bus.req = 8'h01;
        step();
        bus.req = 8'h00;
        cyc = 0;
        while (!bus.grant_valid && cyc < 8) begin step(); cyc++; end
        total++; if (bus.grant_valid !== 1'b1) begin bad++; $display("FAIL clr_setup got=%b want=1", bus.grant_valid); end
        bus.clear = 1'b1;
        bus.ack   = 1'b1;
        bus.req   = 8'h08;
        step();
        bus.clear = 1'b0;
        bus.ack   = 1'b0;
        bus.req   = 8'h00;
        total++; if (bus.pending !== 8'h00) begin bad++; $display("FAIL clr_pending got=%h want=00", bus.pending); end
        total++; if (bus.grant_valid !== 1'b0 || bus.grant_onehot !== 8'h00) begin bad++; $display("FAIL clr_grant got=%b/%h want=0/00", bus.grant_valid, bus.grant_onehot); end
        step();
        total++; if (bus.pending !== 8'h00 || bus.grant_valid !== 1'b0) begin bad++; $display("FAIL clr_after got=%h/%b want=00/0", bus.pending, bus.grant_valid); end
    endtask

    task automatic test_edge_level();
        int dut_g = 0;
        int mod_g = 0;
        bus.mask = 8'hFF;
        bus.req  = 8'h10;
        for (int c = 0; c < 10; c++) begin
            bus.ack = bus.grant_valid;
            if (bus.grant_valid) dut_g++;
            if (m_gidx >= 0) mod_g++;
            step();
        end
        bus.req = 8'h00;
        bus.ack = 1'b0;
`ifdef REQ_ENC_EDGE_EN
        total++; if (dut_g !== 1) begin bad++; $display("FAIL edge_grants got=%0d want=1", dut_g); end
`else
        total++; if (dut_g < 2) begin bad++; $display("FAIL level_repend got=%0d want>=2", dut_g); end
`endif
        total++; if (dut_g !== mod_g) begin bad++; $display("FAIL held_grants got=%0d want=%0d", dut_g, mod_g); end
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
    endtask

    task automatic test_random();
        logic [N-1:0] e_oh;
        for (int n = 0; n < 400; n++) begin
            bus.req   = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            bus.mask  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
            bus.ack   = 1'($urandom_range(0, 1));
            bus.clear = ($urandom_range(0, 29) == 0);
            step();
            e_oh = (m_gidx >= 0) ? (N'(1) << m_gidx) : '0;
            total++; if (bus.grant_valid !== (m_gidx >= 0)) begin bad++; $display("FAIL rnd_valid n=%0d got=%b want=%b", n, bus.grant_valid, (m_gidx >= 0)); end
            total++; if (bus.grant_onehot !== e_oh) begin bad++; $display("FAIL rnd_onehot n=%0d got=%h want=%h", n, bus.grant_onehot, e_oh); end
            total++; if (bus.pending !== m_pend) begin bad++; $display("FAIL rnd_pending n=%0d got=%h want=%h", n, bus.pending, m_pend); end
            if (m_gidx >= 0) begin
                total++; if (bus.grant_idx !== IW'(m_gidx)) begin bad++; $display("FAIL rnd_idx n=%0d got=%0d want=%0d", n, bus.grant_idx, m_gidx); end
            end
        end
        bus.req   = '0;
        bus.ack   = 1'b0;
        bus.clear = 1'b0;
        bus.mask  = '1;
    endtask

    initial begin
        test_reset();
        test_priority();
        test_no_preempt();
        test_mask();
        test_clear();
        test_edge_level();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
